// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's load/store port. It holds the data
//   memory array and serves one byte/halfword/word request at a time, returning
//   load data or a store acknowledge LATENCY cycles after acceptance.
//
// Parameters
//   XLEN    - data/address width. The byte-lane logic assumes 32.
//   DEPTH   - number of XLEN-bit words in the array (power of two).
//   LATENCY - cycles from acceptance to ack, 1..15.
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   asynchronous active-high reset
//   req    in   request valid; held with all fields until accepted
//   ready  out  responder can accept a request this cycle
//   we     in   1 = store, 0 = load
//   size   in   00 byte, 01 halfword, 10/11 word
//   addr   in   byte address; bits above the word index are ignored (wrap)
//   wdata  in   store data, right-justified
//   ack    out  one-cycle response pulse
//   rdata  out  load data, right-justified, zero-extended; 0 unless ack
//   err    out  misaligned-request flag; 0 unless ack
//
// Build option
//   DMEM_MISALIGN_ERR_EN - when defined, misaligned halfword/word requests do
//   not touch the array and respond with err=1, rdata=0. When undefined, err is
//   always 0 and misaligned addresses are forced to natural alignment.
module data_mem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  output logic            ready,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            ack,
  output logic [XLEN-1:0] rdata,
  output logic            err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;

  // Array contents are never reset.
  logic [XLEN-1:0] mem [DEPTH];

  logic            accept;
  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic [3:0]      strb;
  logic            misal;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] rsp_data;
  logic [XLEN-1:0] data_p1;
  logic            err_p1;
  logic            unused_addr;

  // Byte offset after forcing natural alignment for the access size.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00:   return 4'b0001 << o;
      2'b01:   return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the store data across lanes lets the strobes pick the right copy.
  function automatic logic [XLEN-1:0] replicate(input logic [1:0] sz, input logic [XLEN-1:0] d);
    case (sz)
      2'b00:   return XLEN'({4{d[7:0]}});
      2'b01:   return XLEN'({2{d[15:0]}});
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      sz,
                                                   input logic [1:0]      o);
    logic [XLEN-1:0] shifted;
    shifted = word >> {o, 3'b000};
    case (sz)
      2'b00:   return XLEN'(shifted[7:0]);
      2'b01:   return XLEN'(shifted[15:0]);
      default: return shifted;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_ERR_EN
  assign misal = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // No acceptance (and hence no array write) while reset is held.
  assign accept      = req && ready && !rst;
  assign idx         = addr[AW+1:2];
  assign off         = align_off(size, addr[1:0]);
  assign strb        = lane_strobe(size, off);
  assign wdata_rep   = replicate(size, wdata);
  assign rsp_data    = (we || misal) ? '0 : load_extract(mem[idx], size, off);
  assign unused_addr = ^addr[XLEN-1:AW+2];

  // Stage p0 -> array: stores commit in the acceptance cycle.
  always_ff @(posedge clk) begin
    if (accept && we && !misal) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // Stage p0 -> p1: load result captured at acceptance and held until ack.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= rsp_data;
      err_p1  <= misal;
    end
  end

  // Control FSM; ack/rdata/err are registered and only non-zero in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ready <= 1'b1;
      ack   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready <= 1'b0;
            if (LATENCY == 1) begin
              // Held register is not loaded yet, so present the live result.
              state <= RESP;
              ack   <= 1'b1;
              rdata <= rsp_data;
              err   <= misal;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt reaches 0 on this edge, which is the edge into RESP.
          if (cnt <= 4'd1) begin
            state <= RESP;
            ack   <= 1'b1;
            rdata <= data_p1;
            err   <= err_p1;
          end
        end
        RESP: begin
          state <= IDLE;
          ready <= 1'b1;
          ack   <= 1'b0;
          rdata <= '0;
          err   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          ack   <= 1'b0;
          rdata <= '0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
